mem_stage_unit: RTL

MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

---
 rtl/mem_stage_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: pipeline memory stage. Plain ALU results pass through to
// writeback in one cycle; loads and stores issue a single request to the data
// memory and hold the upstream pipeline register until the memory acks.
// Optional build macro MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES
// cycles in ACCESS without an ack and raise a sticky err_o.
module mem_stage_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wmem_i,
    input  logic        rmem_i,
    input  logic        wreg_i,
    input  logic [3:0]  dest_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  ext_sel_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_wreg_o,
    output logic [3:0]  wb_dest_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    // A zero timeout would abort before the request is ever seen.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_error
        $error("mem_stage_unit: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam logic [1:0] EXT_WORD  = 2'b00;
    localparam logic [1:0] EXT_BYTEU = 2'b01;
    localparam logic [1:0] EXT_BYTES = 2'b10;
    localparam logic [1:0] EXT_HALFS = 2'b11;

    state_t      state;
    logic        is_store_q;
    logic        wreg_q;
    logic [3:0]  dest_q;
    logic [1:0]  ext_q;
    logic [1:0]  lane_q;

    logic        req_in;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;
    logic        timeout_hit;

    assign req_in = rmem_i | wmem_i;

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        be_next    = 4'b1111;
        wdata_next = wdata_i;
        case (ext_sel_i)
            EXT_BYTEU, EXT_BYTES: begin
                be_next    = 4'b0001 << addr_i[1:0];
                wdata_next = {4{wdata_i[7:0]}};
            end
            EXT_HALFS: begin
                be_next    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_next = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Select the addressed lane of the read data and extend it.
    always_comb begin
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        byte_lane = mem_rdata_i[7:0];
        case (lane_q)
            2'd1:    byte_lane = mem_rdata_i[15:8];
            2'd2:    byte_lane = mem_rdata_i[23:16];
            2'd3:    byte_lane = mem_rdata_i[31:24];
            default: ;
        endcase
        half_lane = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_data = mem_rdata_i;
        case (ext_q)
            EXT_BYTEU: load_data = {24'd0, byte_lane};
            EXT_BYTES: load_data = {{24{byte_lane[7]}}, byte_lane};
            EXT_HALFS: load_data = {{16{half_lane[15]}}, half_lane};
            default:   ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // The last permitted ACCESS cycle without an ack ends the access.
    assign timeout_hit = (state == ACCESS) && !mem_ack_i
                         && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles since the request; latch err_o on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_o  <= 1'b0;
        end else begin
            if (state == ACCESS && !mem_ack_i && !timeout_hit)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (timeout_hit)
                err_o <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Hold upstream while a request is being launched or is still outstanding.
    assign stall_o = ((state == IDLE) && req_in)
                   || ((state == ACCESS) && !mem_ack_i && !timeout_hit);

    // Stage FSM with registered memory and writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples values from before the edge, independent of statement order.
        if (rst) begin
            state       <= IDLE;
            is_store_q  <= 1'b0;
            wreg_q      <= 1'b0;
            dest_q      <= 4'd0;
            ext_q       <= 2'd0;
            lane_q      <= 2'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            mem_be_o    <= 4'd0;
            wb_valid_o  <= 1'b0;
            wb_wreg_o   <= 1'b0;
            wb_dest_o   <= 4'd0;
            wb_data_o   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_in) begin
                        // A simultaneous load and store is issued as a store.
                        is_store_q  <= wmem_i;
                        wreg_q      <= wreg_i;
                        dest_q      <= dest_i;
                        ext_q       <= ext_sel_i;
                        lane_q      <= addr_i[1:0];
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= wmem_i;
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_wdata_o <= wdata_next;
                        mem_be_o    <= be_next;
                        wb_valid_o  <= 1'b0;
                        state       <= ACCESS;
                    end else begin
                        wb_valid_o <= 1'b1;
                        wb_wreg_o  <= wreg_i;
                        wb_dest_o  <= dest_i;
                        wb_data_o  <= addr_i;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_wreg_o  <= wreg_q & ~is_store_q;
                        wb_dest_o  <= dest_q;
                        wb_data_o  <= is_store_q ? 32'd0 : load_data;
                        state      <= IDLE;
                    end else if (timeout_hit) begin
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_wreg_o  <= 1'b0;
                        wb_dest_o  <= dest_q;
                        wb_data_o  <= 32'd0;
                        state      <= IDLE;
                    end else begin
                        wb_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
